// File: rtl/chan_bin_packetizer.sv
`default_nettype none
// ==========================================================================
// chan_bin_packetizer : bin-mask filter and fixed-length packet framer
// Optional feature macro: CHAN_PKT_FRAME_ALIGN_EN (close packets at frame end)
// Revision: 1.0
// ==========================================================================
module chan_bin_packetizer #(
   parameter int DATA_WIDTH = 32,
   parameter int BIN_WIDTH  = 11,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  sync_reset_n,
   input  logic [LEN_WIDTH-1:0]  payload_length,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [BIN_WIDTH-1:0]  s_axis_tuser,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [31:0]           s_axis_select_tdata,
   input  logic                  s_axis_select_tlast,
   input  logic                  s_axis_select_tvalid,
   output logic                  s_axis_select_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready
);
   localparam int NWORDS = 2 ** (BIN_WIDTH - 5);
   localparam int PW     = BIN_WIDTH - 4;
   localparam int CW     = LEN_WIDTH - 2;

   typedef enum logic [0:0] {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

   logic [31:0]          active_mask [NWORDS];
   logic [31:0]          shadow_mask [NWORDS];
   logic [PW-1:0]        wr_ptr;
   logic                 commit_pending;
   logic [BIN_WIDTH-6:0] widx;
   logic [4:0]           bidx;
   logic                 accept, swap, mask_bit, sel;
   logic [1:0]           unused_len_lsb;

   assign s_axis_select_tready = 1'b1;
   assign unused_len_lsb       = payload_length[1:0];
   assign widx     = s_axis_tuser[BIN_WIDTH-1:5];
   assign bidx     = s_axis_tuser[4:0];
   assign accept   = s_axis_tvalid && s_axis_tready;
   assign swap     = accept && commit_pending && (s_axis_tuser == '0);
   // The swapping bin-0 beat is already judged by the incoming mask.
   assign mask_bit = swap ? shadow_mask[0][0] : active_mask[widx][bidx];
   assign sel      = accept && mask_bit;

   always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
         for (int k = 0; k < NWORDS; k++) begin
            active_mask[k] <= '1;
            shadow_mask[k] <= '1;
         end
         wr_ptr         <= '0;
         commit_pending <= 1'b0;
      end else begin
         if (swap) begin
            active_mask    <= shadow_mask;
            commit_pending <= 1'b0;
         end
         if (s_axis_select_tvalid) begin
            if (wr_ptr < PW'(NWORDS))
               shadow_mask[wr_ptr[PW-2:0]] <= s_axis_select_tdata;
            if (s_axis_select_tlast) begin
               wr_ptr         <= '0;
               commit_pending <= 1'b1;
            end else if (wr_ptr < PW'(NWORDS)) begin
               wr_ptr <= wr_ptr + PW'(1);
            end
         end
      end
   end

   state_t          state, state_nx;
   logic [CW-1:0]   count, count_nx, pkt_len, pkt_len_nx, req_len;
   logic            beat_last;

   assign req_len = (payload_length[LEN_WIDTH-1:2] == '0) ? CW'(1)
                                                          : payload_length[LEN_WIDTH-1:2];

`ifdef CHAN_PKT_FRAME_ALIGN_EN
   logic frame_close;
   assign frame_close = accept && !mask_bit && s_axis_tlast && (state == IN_PKT);
`endif

   always_comb begin
      state_nx   = state;
      count_nx   = count;
      pkt_len_nx = pkt_len;
      beat_last  = 1'b0;
      if (sel) begin
         if (state == IDLE) begin
            pkt_len_nx = req_len;
            if (req_len == CW'(1)) begin
               beat_last = 1'b1;
               count_nx  = '0;
            end else begin
               count_nx = CW'(1);
               state_nx = IN_PKT;
            end
         end else if (count + CW'(1) == pkt_len) begin
            beat_last = 1'b1;
            count_nx  = '0;
            state_nx  = IDLE;
         end else begin
            count_nx = count + CW'(1);
         end
      end
`ifdef CHAN_PKT_FRAME_ALIGN_EN
      if ((sel && s_axis_tlast) || frame_close) begin
         beat_last = sel;
         count_nx  = '0;
         state_nx  = IDLE;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
         state   <= IDLE;
         count   <= '0;
         pkt_len <= '0;
      end else begin
         state   <= state_nx;
         count   <= count_nx;
         pkt_len <= pkt_len_nx;
      end
   end

   // Two-entry output buffer; entry 0 drives the master port, bit DATA_WIDTH is tlast.
   logic [DATA_WIDTH:0]  buf_q [2];
   logic [DATA_WIDTH:0]  push_word;
   logic [1:0]           fill;
   logic                 push, pop;

   assign pop = (fill != 2'd0) && m_axis_tready;

`ifdef CHAN_PKT_FRAME_ALIGN_EN
   logic                  h_valid, h_last, h_move;
   logic [DATA_WIDTH-1:0] h_data;

   // One-entry hold lets a following unselected frame-last beat close the packet.
   assign h_move        = h_valid && (fill != 2'd2);
   assign push          = h_move;
   assign push_word     = {h_last | frame_close, h_data};
   assign s_axis_tready = sync_reset_n && (!h_valid || (fill != 2'd2));

   always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
         h_valid <= 1'b0;
         h_last  <= 1'b0;
         h_data  <= '0;
      end else if (sel) begin
         h_valid <= 1'b1;
         h_last  <= beat_last;
         h_data  <= s_axis_tdata;
      end else if (h_move) begin
         h_valid <= 1'b0;
      end else if (frame_close) begin
         h_last  <= 1'b1;
      end
   end
`else
   logic unused_frame_last;
   assign unused_frame_last = s_axis_tlast;
   assign push          = sel;
   assign push_word     = {beat_last, s_axis_tdata};
   assign s_axis_tready = sync_reset_n && (fill != 2'd2);
`endif

   always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
         fill     <= 2'd0;
         buf_q[0] <= '0;
         buf_q[1] <= '0;
      end else begin
         if (pop && push) begin
            buf_q[0] <= push_word;
         end else if (pop) begin
            buf_q[0] <= buf_q[1];
         end else if (push) begin
            if (fill == 2'd0) buf_q[0] <= push_word;
            else              buf_q[1] <= push_word;
         end
         fill <= fill + {1'b0, push} - {1'b0, pop};
      end
   end

   assign m_axis_tvalid = (fill != 2'd0);
   assign m_axis_tdata  = buf_q[0][DATA_WIDTH-1:0];
   assign m_axis_tlast  = buf_q[0][DATA_WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_chan_bin_packetizer.sv
`default_nettype none
// Bench for chan_bin_packetizer: directed frames checked against a queue-based model.
module tb_chan_bin_packetizer;
   logic        clk = 1'b0;
   logic        sync_reset_n = 1'b0;
   logic [15:0] payload_length = 16'd16;
   logic [31:0] s_tdata = '0;
   logic [10:0] s_tuser = '0;
   logic        s_tlast = 1'b0, s_tvalid = 1'b0;
   logic        s_axis_tready;
   logic [31:0] sel_tdata = '0;
   logic        sel_tlast = 1'b0, sel_tvalid = 1'b0, sel_tready;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tlast, m_axis_tvalid;
   logic        m_tready = 1'b1;

   int checks = 0;
   int errors = 0;

`ifdef CHAN_PKT_FRAME_ALIGN_EN
   localparam bit FIRST_VALID = 1'b0;
`else
   localparam bit FIRST_VALID = 1'b1;
`endif

   chan_bin_packetizer dut (
      .clk(clk), .sync_reset_n(sync_reset_n), .payload_length(payload_length),
      .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_select_tdata(sel_tdata), .s_axis_select_tlast(sel_tlast),
      .s_axis_select_tvalid(sel_tvalid), .s_axis_select_tready(sel_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_tready)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   bit          act [2048];
   bit          shd [2048];
   bit          commit;
   int          ptr, plen, pos;
   logic [32:0] exp_q [$];
   logic [32:0] obs [$];

   function automatic void model_reset();
      foreach (act[i]) begin act[i] = 1'b1; shd[i] = 1'b1; end
      commit = 1'b0; ptr = 0; pos = 0; plen = 1;
      exp_q.delete();
   endfunction

   function automatic void model_select(input logic [31:0] w, input bit last);
      if (ptr < 64) begin
         for (int i = 0; i < 32; i++) shd[ptr*32 + i] = w[i];
         ptr++;
      end
      if (last) begin commit = 1'b1; ptr = 0; end
   endfunction

   function automatic void model_beat(input int bin, input logic [31:0] d, input bit flast);
      bit last;
      if (commit && bin == 0) begin act = shd; commit = 1'b0; end
      if (!act[bin]) begin
`ifdef CHAN_PKT_FRAME_ALIGN_EN
         if (flast && pos > 0) begin
            if (exp_q.size() > 0) exp_q[exp_q.size()-1][32] = 1'b1;
            pos = 0;
         end
`endif
         return;
      end
      if (pos == 0) plen = ((payload_length >> 2) == 0) ? 1 : int'(payload_length >> 2);
      pos++;
      last = (pos == plen);
`ifdef CHAN_PKT_FRAME_ALIGN_EN
      if (flast) last = 1'b1;
`endif
      if (last) pos = 0;
      exp_q.push_back({last, d});
   endfunction

   function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
      end
   endfunction

   function automatic logic [63:0] last_mask();
      logic [63:0] m = '0;
      foreach (obs[k]) if (k < 64) m[k] = obs[k][32];
      return m;
   endfunction

   // ---------------- compare process ----------------
   logic        stalled = 1'b0;
   logic [32:0] held;
   always begin
      @(negedge clk);
      #2;
      if (sync_reset_n && stalled) begin
         checks++;
         if (!m_axis_tvalid || {m_axis_tlast, m_axis_tdata} !== held) begin
            errors++;
            $display("FAIL hold_stable: got v=%0b 0x%0h, want 0x%0h", m_axis_tvalid,
                     {m_axis_tlast, m_axis_tdata}, held);
         end
      end
      if (sync_reset_n && m_axis_tvalid && m_tready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected: got 0x%0h, want no output", {m_axis_tlast, m_axis_tdata});
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            if ({m_axis_tlast, m_axis_tdata} !== e) begin
               errors++;
               $display("FAIL out_beat: got last=%0b data=0x%0h, want last=%0b data=0x%0h",
                        m_axis_tlast, m_axis_tdata, e[32], e[31:0]);
            end
         end
         obs.push_back({m_axis_tlast, m_axis_tdata});
      end
      stalled = sync_reset_n && m_axis_tvalid && !m_tready;
      held    = {m_axis_tlast, m_axis_tdata};
   end

   // ---------------- stimulus tasks (called at negedge) ----------------
   task automatic send(input int bin, input logic [31:0] d, input bit fl);
      int g = 0;
      s_tvalid = 1'b1; s_tuser = bin[10:0]; s_tdata = d; s_tlast = fl;
      #1;
      while (!s_axis_tready && g < 200) begin @(negedge clk); #1; g++; end
      if (!s_axis_tready) chk("send_timeout", 64'd0, 64'd1);
      else model_beat(bin, d, fl);
      @(negedge clk);
      s_tvalid = 1'b0; s_tlast = 1'b0;
   endtask

   task automatic load_sel(input logic [31:0] w, input bit last);
      sel_tvalid = 1'b1; sel_tdata = w; sel_tlast = last;
      model_select(w, last);
      @(negedge clk);
      sel_tvalid = 1'b0; sel_tlast = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      while ((exp_q.size() != 0 || m_axis_tvalid) && g < 300) begin @(negedge clk); g++; end
      if (g >= 300) chk("drain_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      chk("rst_s_tready", s_axis_tready, 0);
      chk("rst_m_tvalid", m_axis_tvalid, 0);
      chk("rst_sel_tready", sel_tready, 1);
      @(negedge clk);
      sync_reset_n = 1'b1;
      model_reset();
      #1;
      chk("rel_s_tready", s_axis_tready, 1);
      chk("rel_outputs", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, 0);
      @(negedge clk);

      // 1: all-pass mask, 4-sample packets, first-output latency
      obs.delete();
      send(0, 32'h100, 1'b0);
      #2;
      chk("t1_latency", m_axis_tvalid, FIRST_VALID);
      for (int b = 1; b < 8; b++) send(b, 32'h100 + b, 1'b0);
      drain();
      chk("t1_count", obs.size(), 8);
      chk("t1_lastmask", last_mask(), 64'h88);
      chk("t1_first", obs[0], {1'b0, 32'h100});
      chk("t1_final", obs[7], {1'b1, 32'h107});

      // 3: output back-pressure
      obs.delete();
      fork
         begin
            for (int k = 0; k < 12; k++) send(k, 32'h300 + k, 1'b0);
         end
         begin
            m_tready = 1'b0;
            repeat (6) @(negedge clk);
            #1;
            chk("t3_stall_s_tready", s_axis_tready, 0);
            chk("t3_stall_head", {m_axis_tvalid, m_axis_tdata}, {1'b1, 32'h300});
            repeat (4) @(negedge clk);
            m_tready = 1'b1;
         end
      join
      drain();
      chk("t3_count", obs.size(), 12);
      chk("t3_final", obs[11], {1'b1, 32'h30b});

      // 4: payload_length change mid-packet
      obs.delete();
      payload_length = 16'd16;
      send(0, 32'h400, 1'b0);
      send(1, 32'h401, 1'b0);
      payload_length = 16'd32;
      for (int k = 2; k < 12; k++) send(k, 32'h400 + k, 1'b0);
      drain();
      chk("t4_count", obs.size(), 12);
      chk("t4_lastmask", last_mask(), 64'h808);

      // 2: mask load mid-frame, swap at next bin 0
      obs.delete();
      payload_length = 16'd16;
      for (int b = 0; b <= 10; b++) send(b, 32'h200 + b, 1'b0);
      load_sel(32'h0000_0005, 1'b1);
      chk("t2_commit_set", dut.commit_pending, 1);
      for (int b = 11; b < 32; b++) send(b, 32'h200 + b, 1'b0);
      send(0, 32'h280, 1'b0);
      chk("t2_commit_clear", dut.commit_pending, 0);
      for (int b = 1; b < 32; b++) send(b, 32'h280 + b, 1'b0);
      for (int b = 0; b < 4; b++) send(b, 32'h2c0 + b, 1'b0);
      drain();
      chk("t2_count", obs.size(), 36);
      chk("t2_frameb_bin0", obs[32], {1'b0, 32'h280});
      chk("t2_frameb_bin2", obs[33], {1'b0, 32'h282});
      chk("t2_tail", obs[35], {1'b1, 32'h2c2});

      // 5: single-sample packets, then reset mid-packet
      obs.delete();
      payload_length = 16'd2;
      for (int b = 0; b < 4; b++) send(b, 32'h500 + b, 1'b0);
      drain();
      chk("t5_count", obs.size(), 2);
      chk("t5_lastmask", last_mask(), 64'h3);
      chk("t5_second", obs[1], {1'b1, 32'h502});
      m_tready = 1'b0;
      payload_length = 16'd16;
      send(0, 32'h510, 1'b0);
      send(2, 32'h512, 1'b0);
      sync_reset_n = 1'b0;
      model_reset();
      @(negedge clk);
      m_tready = 1'b1;
      #1;
      chk("t5_rst_outputs", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, 0);
      chk("t5_rst_s_tready", s_axis_tready, 0);
      @(negedge clk);
      sync_reset_n = 1'b1;
      obs.delete();
      for (int b = 1; b < 8; b += 2) send(b, 32'h600 + b, 1'b0);
      drain();
      chk("t5_post_count", obs.size(), 4);
      chk("t5_post_first", obs[0], {1'b0, 32'h601});
      chk("t5_post_last", obs[3], {1'b1, 32'h607});

`ifdef CHAN_PKT_FRAME_ALIGN_EN
      // 6: frame-aligned short packets
      obs.delete();
      payload_length = 16'd64;
      for (int b = 0; b < 6; b++) send(b, 32'h700 + b, b == 5);
      drain();
      chk("t6_count", obs.size(), 6);
      chk("t6_lastmask", last_mask(), 64'h20);
      load_sel(32'hffff_ffdf, 1'b1);
      obs.delete();
      for (int b = 0; b < 6; b++) send(b, 32'h720 + b, b == 5);
      drain();
      chk("t6m_count", obs.size(), 5);
      chk("t6m_lastmask", last_mask(), 64'h10);
`endif

      chk("final_queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
